spi_pwm_config: RTL and testbench



---
 rtl/spi_pwm_config_if.sv | 16 +
 rtl/spi_pwm_config.sv | 173 +++++++++++++++++
 tb/tb_spi_pwm_config.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/spi_pwm_config_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_pwm_config_if
// Brief    : SPI pin bundle (SCLK/COPI/nCS/CIPO) between controller and peripheral.
// Revision : 1.0
// ============================================================================
interface spi_pwm_config_if;
    logic sclk;
    logic copi;
    logic ncs;
    logic cipo;

    modport master (output sclk, output copi, output ncs, input cipo);
    modport slave  (input sclk, input copi, input ncs, output cipo);
endinterface
`default_nettype wire

// File: rtl/spi_pwm_config.sv
`default_nettype none
// ============================================================================
// Module   : spi_pwm_config
// Brief    : SPI write-frame receiver driving five 8-bit PWM config registers.
//            Optional readback on CIPO enabled by macro SPI_READBACK_EN.
// Revision : 1.0
// ============================================================================
module spi_pwm_config #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic             clk,
    input  logic             rst,
    spi_pwm_config_if.slave  spi,
    output logic [7:0]       en_reg_out_7_0,
    output logic [7:0]       en_reg_out_15_8,
    output logic [7:0]       en_reg_pwm_7_0,
    output logic [7:0]       en_reg_pwm_15_8,
    output logic [7:0]       pwm_duty_cycle,
    output logic             wr_strobe
);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_shift  = 2'd1;
    localparam logic [1:0] c_commit = 2'd2;
    localparam logic [6:0] c_max_addr = 7'(MAX_ADDR);
    localparam logic [4:0] c_cnt_sat  = 5'd17;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_copi_sync;
    logic [SYNC_STAGES-1:0] r_ncs_sync;
    logic                   r_sclk_hist;
    logic                   r_ncs_hist;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic [15:0] r_shift;
    logic [7:0]  r_cfg [0:4];

    logic        w_sclk_s;
    logic        w_copi_s;
    logic        w_ncs_s;
    logic        w_sclk_rise;
    logic        w_ncs_fall;
    logic        w_ncs_rise;
    logic [15:0] w_next_shift;
    logic        w_frame_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_copi_sync <= '0;
            r_ncs_sync  <= '1;
            r_sclk_hist <= 1'b0;
            r_ncs_hist  <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.sclk};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], spi.copi};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0],  spi.ncs};
            r_sclk_hist <= r_sclk_sync[SYNC_STAGES-1];
            r_ncs_hist  <= r_ncs_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk_s     = r_sclk_sync[SYNC_STAGES-1];
    assign w_copi_s     = r_copi_sync[SYNC_STAGES-1];
    assign w_ncs_s      = r_ncs_sync[SYNC_STAGES-1];
    assign w_sclk_rise  = w_sclk_s & ~r_sclk_hist;
    assign w_ncs_fall   = ~w_ncs_s & r_ncs_hist;
    assign w_ncs_rise   = w_ncs_s & ~r_ncs_hist;
    assign w_next_shift = {r_shift[14:0], w_copi_s};
    assign w_frame_ok   = (r_cnt == 5'd16) && r_shift[15] && (r_shift[14:8] <= c_max_addr);

    // The write lands on the SHIFT->COMMIT edge; COMMIT is the cycle wr_strobe is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_idle;
            r_cnt     <= '0;
            r_shift   <= '0;
            wr_strobe <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                r_cfg[i] <= '0;
            end
        end else begin
            wr_strobe <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (w_ncs_fall) begin
                        r_state <= c_shift;
                        r_cnt   <= '0;
                        r_shift <= '0;
                    end
                end
                c_shift: begin
                    if (w_ncs_rise) begin
                        r_state <= c_commit;
                        if (w_frame_ok) begin
                            wr_strobe <= 1'b1;
                            for (int i = 0; i < 5; i++) begin
                                if (r_shift[14:8] == 7'(i)) begin
                                    r_cfg[i] <= r_shift[7:0];
                                end
                            end
                        end
                    end else if (w_sclk_rise) begin
                        r_shift <= w_next_shift;
                        if (r_cnt != c_cnt_sat) begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                end
                c_commit: begin
                    r_state <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign en_reg_out_7_0  = r_cfg[0];
    assign en_reg_out_15_8 = r_cfg[1];
    assign en_reg_pwm_7_0  = r_cfg[2];
    assign en_reg_pwm_15_8 = r_cfg[3];
    assign pwm_duty_cycle  = r_cfg[4];

`ifdef SPI_READBACK_EN
    logic       w_sclk_fall;
    logic [6:0] w_rd_addr;
    logic [7:0] w_rd_data;
    logic [7:0] r_rd_shift;
    logic       r_rd_active;
    logic       r_cipo;

    assign w_sclk_fall = ~w_sclk_s & r_sclk_hist;
    assign w_rd_addr   = w_next_shift[6:0];

    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < 5; i++) begin
            if ((w_rd_addr == 7'(i)) && (w_rd_addr <= c_max_addr)) begin
                w_rd_data = r_cfg[i];
            end
        end
    end

    // Header is complete on the 8th rising edge; the register is captured then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cipo      <= 1'b0;
            r_rd_active <= 1'b0;
            r_rd_shift  <= '0;
        end else if ((r_state != c_shift) || w_ncs_rise) begin
            r_cipo      <= 1'b0;
            r_rd_active <= 1'b0;
        end else if (w_sclk_rise && (r_cnt == 5'd7) && !w_next_shift[7]) begin
            r_rd_active <= 1'b1;
            r_cipo      <= w_rd_data[7];
            r_rd_shift  <= {w_rd_data[6:0], 1'b0};
        end else if (w_sclk_fall && r_rd_active) begin
            r_cipo      <= r_rd_shift[7];
            r_rd_shift  <= {r_rd_shift[6:0], 1'b0};
        end
    end

    assign spi.cipo = r_cipo;
`else
    assign spi.cipo = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_pwm_config.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_pwm_config
// Brief    : Scoreboard bench for spi_pwm_config; expected register images queued
//            per frame and compared by a monitor on every wr_strobe.
// Revision : 1.0
// ============================================================================
module tb_spi_pwm_config;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_pwm_config_if spi ();

    logic [7:0]  r0, r1, r2, r3, r4;
    logic        wr_strobe;
    logic [39:0] regs_now;

    spi_pwm_config dut (
        .clk             (clk),
        .rst             (rst),
        .spi             (spi),
        .en_reg_out_7_0  (r0),
        .en_reg_out_15_8 (r1),
        .en_reg_pwm_7_0  (r2),
        .en_reg_pwm_15_8 (r3),
        .pwm_duty_cycle  (r4),
        .wr_strobe       (wr_strobe)
    );

    assign regs_now = {r4, r3, r2, r1, r0};

    int          total   = 0;
    int          bad     = 0;
    int          strobes = 0;
    logic [39:0] sbq [$];

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && wr_strobe === 1'b1) begin
            strobes++;
            if (sbq.size() == 0) chk("unexpected_strobe", 40'(sbq.size()), 40'd1);
            else                 chk("sb_regs", regs_now, sbq.pop_front());
        end
    end

    function automatic logic exp_cipo(input logic is_read, input logic [7:0] rd,
                                      input int k, input logic after_fall);
        int idx;
`ifdef SPI_READBACK_EN
        idx = after_fall ? (14 - k) : (15 - k);
        if (!is_read || k < 8 || idx < 0) return 1'b0;
        return rd[idx];
`else
        idx = k;
        return 1'b0;
`endif
    endfunction

    task automatic send(input logic [15:0] frame, input int nbits, input logic [39:0] exp,
                        input logic exp_wr, input logic is_read, input logic [7:0] rd);
        int exp_strobes;
        exp_strobes = strobes + (exp_wr ? 1 : 0);
        if (exp_wr) sbq.push_back(exp);
        spi.ncs = 1'b0;
        wait_n(4);
        for (int k = 1; k <= nbits; k++) begin
            spi.copi = (k <= 16) ? frame[16-k] : 1'b0;
            wait_n(4);
            spi.sclk = 1'b1;
            wait_n(4);
            chk($sformatf("cipo_rise%0d", k), 40'(spi.cipo), 40'(exp_cipo(is_read, rd, k, 1'b0)));
            spi.sclk = 1'b0;
            wait_n(4);
            chk($sformatf("cipo_fall%0d", k), 40'(spi.cipo), 40'(exp_cipo(is_read, rd, k, 1'b1)));
        end
        spi.ncs = 1'b1;
        if (exp_wr) begin
            repeat (3) @(posedge clk);
            #1 chk("latency_strobe", 40'(wr_strobe), 40'd1);
        end
        wait_n(8);
        chk("strobe_count", 40'(strobes), 40'(exp_strobes));
        chk("regs_after_frame", regs_now, exp);
        chk("cipo_idle", 40'(spi.cipo), 40'd0);
    endtask

    initial begin
        rst      = 1'b1;
        spi.ncs  = 1'b1;
        spi.sclk = 1'b0;
        spi.copi = 1'b0;
        wait_n(4);
        chk("reset_regs",   regs_now, 40'h0);
        chk("reset_strobe", 40'(wr_strobe), 40'd0);
        chk("reset_cipo",   40'(spi.cipo), 40'd0);
        rst = 1'b0;
        wait_n(4);

        send(16'h80FF, 16, 40'h00_00_00_00_FF, 1'b1, 1'b0, 8'h00);
        send(16'h8480, 16, 40'h80_00_00_00_FF, 1'b1, 1'b0, 8'h00);
        send(16'h8401, 16, 40'h01_00_00_00_FF, 1'b1, 1'b0, 8'h00);
        send(16'h8555, 16, 40'h01_00_00_00_FF, 1'b0, 1'b0, 8'h00);
        send(16'h8233, 15, 40'h01_00_00_00_FF, 1'b0, 1'b0, 8'h00);
        send(16'h8233, 17, 40'h01_00_00_00_FF, 1'b0, 1'b0, 8'h00);
        send(16'h81C3, 16, 40'h01_00_00_C3_FF, 1'b1, 1'b0, 8'h00);
        send(16'h0100, 16, 40'h01_00_00_C3_FF, 1'b0, 1'b1, 8'hC3);
        send(16'h8000,  0, 40'h01_00_00_C3_FF, 1'b0, 1'b0, 8'h00);
        send(16'h8401, 16, 40'h01_00_00_C3_FF, 1'b1, 1'b0, 8'h00);

        // SCLK activity with chip select high must be ignored
        spi.copi = 1'b1;
        for (int i = 0; i < 5; i++) begin
            spi.sclk = 1'b1; wait_n(4);
            spi.sclk = 1'b0; wait_n(4);
        end
        spi.copi = 1'b0;
        wait_n(8);
        chk("ncs_high_sclk_regs",   regs_now, 40'h01_00_00_C3_FF);
        chk("ncs_high_sclk_strobe", 40'(strobes), 40'd5);

        // Abort a 0x83AA write after 9 bits with reset
        spi.ncs = 1'b0;
        wait_n(4);
        for (int k = 1; k <= 9; k++) begin
            spi.copi = (k == 1 || k == 7 || k == 8 || k == 9) ? 1'b1 : 1'b0;
            wait_n(4); spi.sclk = 1'b1;
            wait_n(4); spi.sclk = 1'b0;
        end
        wait_n(2);
        rst = 1'b1;
        wait_n(3);
        spi.ncs  = 1'b1;
        spi.copi = 1'b0;
        wait_n(3);
        rst = 1'b0;
        wait_n(8);
        chk("abort_regs",   regs_now, 40'h0);
        chk("abort_strobe", 40'(strobes), 40'd5);

        send(16'h83AA, 16, 40'h00_AA_00_00_00, 1'b1, 1'b0, 8'h00);

        chk("queue_empty", 40'(sbq.size()), 40'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
